// File: rtl/mux4_arbiter.sv
// mux4_arbiter
//   Round-robin arbiter that shares a 4:1 data multiplexer among four
//   requesters. A registered one-hot grant selects one requester. Each
//   granted cycle with the grantee still requesting is a "beat": the
//   selected word is captured into y and y_valid pulses for that cycle.
//   A grant is held for at most MAX_BURST beats while another requester
//   is waiting. After that, the grant rotates to the next requester.
//
//   Optional feature (compile-time macro MUX4_ARB_FIXED_PRIO_EN):
//     When this macro is defined, the arbiter uses fixed priority
//     (requester 0 is highest) with no burst limit. A grant is then held
//     until the grantee drops req. ptr and cnt stay at 0 in this mode.
//
//   Parameters
//     DW        data width of d0..d3 and y
//     MAX_BURST beats per grant before forced rotation (>= 1)
//
//   Ports
//     clk      rising-edge clock
//     rst_n    asynchronous active-low reset
//     req      per-requester request lines
//     d0..d3   requester data, valid while the matching req bit is high
//     gnt      registered one-hot grant, zero when idle
//     sel      registered mux select (current or last grantee)
//     y        registered output word
//     y_valid  one-cycle strobe per transferred beat
//     busy     high while a grant is active
module mux4_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d3,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic [DW-1:0] y,
  output logic          y_valid,
  output logic          busy
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nxt;
  logic [1:0]    ptr, ptr_nxt;
  logic [1:0]    sel_nxt;
  logic [3:0]    gnt_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] y_nxt;
  logic          y_valid_nxt;
  logic [DW-1:0] d_sel;
  logic          beat;
  logic          rearb;
  logic [2:0]    win;  // {found, index}

  // Scan req starting at 'start' and wrapping. The lowest offset wins,
  // so the loop runs from high to low offset and the last hit is kept.
  function automatic logic [2:0] pick_rr(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Lowest set index wins.
  function automatic logic [2:0] pick_fixed(input logic [3:0] r);
    logic [2:0] res;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      if (r[k]) res = {1'b1, 2'(k)};
    end
    return res;
  endfunction

  always_comb begin
    d_sel = d0;
    case (sel)
      2'd0: d_sel = d0;
      2'd1: d_sel = d1;
      2'd2: d_sel = d2;
      2'd3: d_sel = d3;
      default: d_sel = d0;
    endcase
  end

  assign beat = (state == GRANT) && req[sel];

`ifdef MUX4_ARB_FIXED_PRIO_EN
  assign win   = pick_fixed(req);
  assign rearb = ((state == IDLE) && (req != 4'b0000)) ||
                 ((state == GRANT) && !req[sel]);
`else
  logic [3:0] others;
  // Requesters other than the current grantee that are waiting.
  assign others = req & ~(4'b0001 << sel);
  assign win    = pick_rr(req, ptr);
  assign rearb  = ((state == IDLE) && (req != 4'b0000)) ||
                  ((state == GRANT) && !req[sel]) ||
                  (beat && (cnt == CNT_LAST) && (others != 4'b0000));
`endif

  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel;
    gnt_nxt     = gnt;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    y_nxt       = y;
    y_valid_nxt = 1'b0;

    if (beat) begin
      y_nxt       = d_sel;
      y_valid_nxt = 1'b1;
      // When no other requester is waiting at the limit, the count wraps and the grant is held.
      cnt_nxt     = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end

    if (rearb) begin
      if (win[2]) begin
        state_nxt = GRANT;
        sel_nxt   = win[1:0];
        gnt_nxt   = 4'b0001 << win[1:0];
        ptr_nxt   = win[1:0] + 2'd1;
        cnt_nxt   = '0;
      end else begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
      end
    end

`ifdef MUX4_ARB_FIXED_PRIO_EN
    ptr_nxt = 2'd0;
    cnt_nxt = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= 4'b0000;
      sel     <= 2'd0;
      ptr     <= 2'd0;
      cnt     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      sel     <= sel_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
      y       <= y_nxt;
      y_valid <= y_valid_nxt;
    end
  end

  assign busy = (state == GRANT);

endmodule

// File: tb/tb_mux4_arbiter.sv
module tb_mux4_arbiter;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req;
  logic [DW-1:0] d0, d1, d2, d3;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] y;
  logic          y_valid;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_beats  = 0;
  int b0;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  mux4_arbiter #(.DW(DW), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .gnt(gnt), .sel(sel), .y(y), .y_valid(y_valid), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every transferred beat is matched against the next expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && y_valid === 1'b1) begin
      n_beats++;
      if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
      else                check("y_beat", 32'(y), 32'(sb.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] eg;
    rst_n = 1'b0;
    req = 4'b0000;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    step(2);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_y", 32'(y), 32'h0);
    check("rst_yv", 32'(y_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    step(1);

    // Single requester: three beats then release.
    repeat (3) sb.push_back(8'h1a);
    d1 = 8'h1a; req = 4'b0010; b0 = n_beats;
    step(1);
    check("single_gnt", 32'(gnt), 32'b0010);
    check("single_busy", 32'(busy), 32'h1);
    check("single_yv0", 32'(y_valid), 32'h0);
    step(3);
    check("single_yv3", 32'(y_valid), 32'h1);
    req = 4'b0000;
    step(1);
    check("single_idle_gnt", 32'(gnt), 32'h0);
    check("single_idle_busy", 32'(busy), 32'h0);
    check("single_idle_yv", 32'(y_valid), 32'h0);
    check("single_beats", 32'(n_beats - b0), 32'd3);

    // Lone requester passes the burst limit without losing the grant.
    repeat (9) sb.push_back(8'h5c);
    d3 = 8'h5c; req = 4'b1000; b0 = n_beats;
    step(1);
    check("lone_gnt0", 32'(gnt), 32'b1000);
    for (int i = 1; i <= 9; i++) begin
      step(1);
      check("lone_gnt", 32'(gnt), 32'b1000);
      check("lone_yv", 32'(y_valid), 32'h1);
    end
    req = 4'b0000;
    step(1);
    check("lone_idle", 32'(busy), 32'h0);
    check("lone_beats", 32'(n_beats - b0), 32'd9);

`ifndef MUX4_ARB_FIXED_PRIO_EN
    // All four requesting: four beats each in turn, then back to 0.
    d0 = 8'h00; d1 = 8'h01; d2 = 8'h10; d3 = 8'h11;
    repeat (4) sb.push_back(8'h00);
    repeat (4) sb.push_back(8'h01);
    repeat (4) sb.push_back(8'h10);
    repeat (4) sb.push_back(8'h11);
    sb.push_back(8'h00);
    req = 4'b1111;
    for (int k = 0; k <= 17; k++) begin
      step(1);
      eg = 4'b0001 << ((k / 4) % 4);
      check("rot_gnt", 32'(gnt), 32'(eg));
    end
    req = 4'b0000;
    step(1);
    check("rot_idle", 32'(busy), 32'h0);
`else
    // Fixed priority: requester 0 keeps the grant indefinitely.
    d0 = 8'hef; d1 = 8'h01; d2 = 8'h10; d3 = 8'h11;
    repeat (11) sb.push_back(8'hef);
    req = 4'b1111;
    for (int k = 0; k <= 11; k++) begin
      step(1);
      check("fix_gnt", 32'(gnt), 32'b0001);
    end
    req = 4'b0000;
    step(1);
    check("fix_idle", 32'(busy), 32'h0);
`endif

    // Release handover from requester 0 to requester 2.
    d0 = 8'h77;
    sb.push_back(8'h77);
    req = 4'b0001;
    step(1);
    check("ho_gnt0", 32'(gnt), 32'b0001);
    step(1);
    d2 = 8'h2b;
    sb.push_back(8'h2b);
    req = 4'b0100;
    step(1);
    check("ho_sel", 32'(sel), 32'd2);
    check("ho_gnt", 32'(gnt), 32'b0100);
    check("ho_bubble", 32'(y_valid), 32'h0);
    step(1);
    check("ho_yv", 32'(y_valid), 32'h1);
    check("ho_y", 32'(y), 32'h2b);
    req = 4'b0000;
    step(1);

    // Asynchronous reset in the middle of a grant.
    d1 = 8'h3c;
    repeat (2) sb.push_back(8'h3c);
    req = 4'b0010;
    step(1);
    check("mid_gnt", 32'(gnt), 32'b0010);
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_sel", 32'(sel), 32'h0);
    check("arst_y", 32'(y), 32'h0);
    check("arst_yv", 32'(y_valid), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    step(1);
    rst_n = 1'b1;
    req = 4'b1111;
    step(1);
    check("restart_gnt", 32'(gnt), 32'b0001);
    req = 4'b0000;
    step(2);

    check("sb_left", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
